// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared definitions for the EX-stage multiply/divide unit.
//   DATA_W  - operand / HI / LO width
//   ITER    - radix-2 iterations per operation
//   md_op_e - op select encodings (MULT, MULTU, DIV, DIVU)
//   md_state_e - sequencer states (IDLE, CALC, FIX)
package ex_muldiv_pkg;

    localparam int DATA_W = 32;
    localparam int ITER   = 32;
    localparam int CNT_W  = $clog2(ITER);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

    // op[1] selects divide, op[0] selects unsigned
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/md_signfix.sv
// md_signfix: combinational sign handling around the unsigned radix-2 core.
//   Operand side: a, b, is_signed -> abs_a, abs_b, sign_a, sign_b
//     (signs are 0 for unsigned ops so the core always sees magnitudes).
//   Result side: raw {upper, lower} core result, is_div, latched signs,
//     div_zero -> hi_res, lo_res (architectural HI/LO values).
module md_signfix
    import ex_muldiv_pkg::*;
(
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                is_signed,
    output logic [DATA_W-1:0]   abs_a,
    output logic [DATA_W-1:0]   abs_b,
    output logic                sign_a,
    output logic                sign_b,
    input  logic [2*DATA_W-1:0] raw,
    input  logic                is_div,
    input  logic                res_sign_a,
    input  logic                res_sign_b,
    input  logic                div_zero,
    output logic [DATA_W-1:0]   hi_res,
    output logic [DATA_W-1:0]   lo_res
);

    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quot;
    logic [DATA_W-1:0]   rem;

    always_comb begin
        sign_a = is_signed & a[DATA_W-1];
        sign_b = is_signed & b[DATA_W-1];
        abs_a  = sign_a ? -a : a;
        abs_b  = sign_b ? -b : b;

        prod = (res_sign_a ^ res_sign_b) ? -raw : raw;
        // Divide by zero leaves an all-ones quotient; it must not be negated
        // even if the dividend was negative. The remainder already equals |A|,
        // so restoring signA reproduces A.
        quot = div_zero ? {DATA_W{1'b1}} :
               ((res_sign_a ^ res_sign_b) ? -raw[DATA_W-1:0] : raw[DATA_W-1:0]);
        rem  = res_sign_a ? -raw[2*DATA_W-1:DATA_W] : raw[2*DATA_W-1:DATA_W];

        if (is_div) begin
            hi_res = rem;
            lo_res = quot;
        end else begin
            hi_res = prod[2*DATA_W-1:DATA_W];
            lo_res = prod[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative 32x32 multiply / divide unit with HI/LO registers.
//   clk, reset (sync, active low)
//   start, op, dataA_EX, dataB_EX - operation request, sampled in IDLE only
//   flush                         - abort in-progress op, no HI/LO update
//   wr_hi, wr_lo, wdata           - MTHI/MTLO writes, applied in IDLE only
//   busy                          - high in CALC and FIX
//   done                          - one-cycle pulse after HI/LO update
//   hi, lo                        - architectural HI/LO
// Latency: accept edge, 32 CALC edges, then the FIX edge writes HI/LO.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] dataA_EX,
    input  logic [DATA_W-1:0] dataB_EX,
    input  logic              flush,
    input  logic              wr_hi,
    input  logic              wr_lo,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    md_state_e state_q, state_d;

    logic [CNT_W-1:0]    cnt_q;
    logic                div_q;
    logic                sign_a_q;
    logic                sign_b_q;
    logic                div_zero_q;
    logic [DATA_W-1:0]   m_q;      // multiplicand (mul) or divisor (div) magnitude
    logic [2*DATA_W-1:0] p_q;      // {acc/remainder, multiplier/quotient}

    logic                accept;
    logic [DATA_W-1:0]   abs_a, abs_b;
    logic                sign_a, sign_b;
    logic [DATA_W-1:0]   hi_res, lo_res;
    logic [DATA_W:0]     add_sum;
    logic [DATA_W:0]     trial;
    logic                qbit;
    logic [2*DATA_W-1:0] mul_next;
    logic [2*DATA_W-1:0] div_next;
    logic [2*DATA_W-1:0] p_init;

    assign accept = (state_q == ST_IDLE) & start & ~flush;
    assign busy   = (state_q != ST_IDLE);

    md_signfix u_signfix (
        .a          (dataA_EX),
        .b          (dataB_EX),
        .is_signed  (op_is_signed(op)),
        .abs_a      (abs_a),
        .abs_b      (abs_b),
        .sign_a     (sign_a),
        .sign_b     (sign_b),
        .raw        (p_q),
        .is_div     (div_q),
        .res_sign_a (sign_a_q),
        .res_sign_b (sign_b_q),
        .div_zero   (div_zero_q),
        .hi_res     (hi_res),
        .lo_res     (lo_res)
    );

    // Radix-2 step logic. Multiply: add multiplicand into the upper half when
    // the multiplier LSB is set, then shift the whole pair right. Divide:
    // shift {rem, dividend} left one bit, trial-subtract the divisor, keep the
    // difference only when it did not borrow (non-performing restore).
    always_comb begin
        add_sum  = {1'b0, p_q[2*DATA_W-1:DATA_W]} + (p_q[0] ? {1'b0, m_q} : '0);
        mul_next = {add_sum, p_q[DATA_W-1:1]};

        trial    = p_q[2*DATA_W-1:DATA_W-1] - {1'b0, m_q};
        qbit     = ~trial[DATA_W];
        div_next = {qbit ? trial[DATA_W-1:0] : p_q[2*DATA_W-2:DATA_W-1],
                    p_q[DATA_W-2:0], qbit};

        p_init   = op_is_div(op) ? {{DATA_W{1'b0}}, abs_a} : {{DATA_W{1'b0}}, abs_b};
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)       state_d = ST_CALC;
            ST_CALC: if (cnt_q == '0)  state_d = ST_FIX;
            ST_FIX:                    state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q      <= '0;
            div_q      <= 1'b0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            m_q        <= '0;
            p_q        <= '0;
            hi         <= '0;
            lo         <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wr_hi) hi <= wdata;
                    if (wr_lo) lo <= wdata;
                    if (accept) begin
                        cnt_q      <= CNT_W'(ITER - 1);
                        div_q      <= op_is_div(op);
                        sign_a_q   <= sign_a;
                        sign_b_q   <= sign_b;
                        div_zero_q <= op_is_div(op) & (dataB_EX == '0);
                        m_q        <= op_is_div(op) ? abs_b : abs_a;
                        p_q        <= p_init;
                    end
                end
                ST_CALC: begin
                    if (!flush) begin
                        p_q   <= div_q ? div_next : mul_next;
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_FIX: begin
                    if (!flush) begin
                        hi   <= hi_res;
                        lo   <= lo_res;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dataA_EX, dataB_EX;
    logic        flush, wr_hi, wr_lo;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic chk_en = 1'b0;

    ex_muldiv dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .dataA_EX(dataA_EX), .dataB_EX(dataB_EX), .flush(flush),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference result from plain arithmetic: returns {hi, lo}.
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            2'b00: return sa * sb;
            2'b01: return ua * ub;
            default: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                if (o == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Transaction-level model: a pending result plus a 33-edge countdown.
    logic        m_busy, m_done;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    int          m_cnt;

    always @(posedge clk) begin
        if (!reset) begin
            m_busy = 0; m_done = 0; m_hi = 0; m_lo = 0; m_cnt = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (wr_hi) m_hi = wdata;
                if (wr_lo) m_lo = wdata;
                if (start && !flush) begin
                    m_busy = 1;
                    m_cnt  = 33;
                    m_pend = ref_res(op, dataA_EX, dataB_EX);
                end
            end else if (flush) begin
                m_busy = 0;
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {63'b0, busy}, {63'b0, m_busy});
            chk("done", {63'b0, done}, {63'b0, m_done});
            chk("hi", {32'b0, hi}, {32'b0, m_hi});
            chk("lo", {32'b0, lo}, {32'b0, m_lo});
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clr_in();
        start = 0; flush = 0; wr_hi = 0; wr_lo = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 80) begin tick(); n++; end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle actual=busy required=idle within 80 cycles");
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Start one op; with noise, scramble operands and pulse start/writes
    // only while the DUT must still be busy.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit noise);
        op = o; dataA_EX = a; dataB_EX = b; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 32; i++) begin
            if (noise) begin
                dataA_EX = $urandom; dataB_EX = $urandom; op = 2'($urandom);
                start = 1'($urandom); wr_hi = 1'($urandom); wr_lo = 1'($urandom);
                wdata = $urandom;
            end
            tick();
        end
        clr_in();
        wait_idle();
    endtask

    task automatic directed(input string nm, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int d0 = done_cnt;
        run_op(o, a, b, 1'b1);
        tick();
        chk({nm, "_hi"}, {32'b0, hi}, {32'b0, eh});
        chk({nm, "_lo"}, {32'b0, lo}, {32'b0, el});
        chk({nm, "_pulses"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0;
        reset = 0; clr_in(); op = 0; dataA_EX = 0; dataB_EX = 0; wdata = 0;
        @(posedge clk);
        tick();
        chk_en = 1;
        tick();
        chk("rst_hi", {32'b0, hi}, 64'd0);
        chk("rst_lo", {32'b0, lo}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        reset = 1;
        tick();

        directed("mult",   2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        directed("multu",  2'b01, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
        directed("div",    2'b10, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        directed("divu0",  2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
        directed("divovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        directed("divneg0",2'b10, -32'sd7, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);

        // Latency: done must appear exactly 34 negedges after the start negedge.
        op = 2'b01; dataA_EX = 32'd5; dataB_EX = 32'd6; start = 1;
        d0 = done_cnt;
        tick(); start = 0;
        repeat (33) tick();
        chk("lat_before", 64'(done_cnt - d0), 64'd0);
        chk("lat_done", {63'b0, done}, 64'd1);
        tick();
        chk("lat_lo", {32'b0, lo}, 64'd30);

        // Flush in the middle of a divide after preloading HI/LO.
        wdata = 32'h1234; wr_hi = 1; tick();
        wdata = 32'h5678; wr_hi = 0; wr_lo = 1; tick();
        wr_lo = 0;
        op = 2'b10; dataA_EX = 32'd100; dataB_EX = 32'd7; start = 1;
        tick(); start = 0;
        repeat (9) tick();
        flush = 1; start = 1; tick();
        flush = 0; start = 0;
        chk("flush_busy", {63'b0, busy}, 64'd0);
        d0 = done_cnt;
        repeat (40) tick();
        chk("flush_done", 64'(done_cnt - d0), 64'd0);
        chk("flush_hi", {32'b0, hi}, 64'h1234);
        chk("flush_lo", {32'b0, lo}, 64'h5678);

        // Reset in the middle of CALC with busy-time noise.
        op = 2'b00; dataA_EX = 32'd9; dataB_EX = 32'd9; start = 1;
        tick(); start = 0;
        for (int i = 0; i < 15; i++) begin
            start = 1'($urandom); wr_hi = 1; wdata = $urandom; tick();
        end
        clr_in();
        reset = 0; tick(); reset = 1;
        chk("rstmid_hi", {32'b0, hi}, 64'd0);
        chk("rstmid_lo", {32'b0, lo}, 64'd0);
        chk("rstmid_busy", {63'b0, busy}, 64'd0);
        d0 = done_cnt;
        repeat (40) tick();
        chk("rstmid_done", 64'(done_cnt - d0), 64'd0);

        // Random traffic: start with simultaneous writes, busy noise, rare flush.
        for (int k = 0; k < 150; k++) begin
            op = 2'($urandom); dataA_EX = pick(); dataB_EX = pick();
            wr_hi = 1'($urandom); wr_lo = 1'($urandom); wdata = $urandom;
            start = 1;
            tick();
            clr_in();
            for (int i = 0; i < 36; i++) begin
                dataA_EX = $urandom; dataB_EX = $urandom;
                start = ($urandom_range(0, 7) == 0);
                wr_hi = ($urandom_range(0, 7) == 0);
                wr_lo = ($urandom_range(0, 7) == 0);
                flush = ($urandom_range(0, 39) == 0);
                wdata = $urandom;
                tick();
            end
            clr_in();
            wait_idle();
            tick();
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset: reset==0 at a clk rising edge resets the block.
REQ-003 SHALL have port start  input  1  request to begin the operation selected by op; sampled only in IDLE.
REQ-004 SHALL have port op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports dataA_EX, dataB_EX  input  32 each  forwarded operands: A is multiplicand or dividend, B is multiplier or divisor.
REQ-006 SHALL have port flush  input  1  abort any in-progress operation.
REQ-007 SHALL have ports wr_hi, wr_lo  input  1 each  MTHI/MTLO write enables.
REQ-008 SHALL have port wdata  input  32  MTHI/MTLO write data.
REQ-009 SHALL have port busy  output  1  operation in progress; the hazard unit stalls on this.
REQ-010 SHALL have port done  output  1  one-cycle pulse indicating new HI/LO values are visible.
REQ-011 SHALL have ports hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-012 SHALL implement states IDLE, CALC and FIX.
- IDLE -> CALC on start=1 with flush=0.
- CALC -> FIX after 32 iterations.
- FIX -> IDLE.
REQ-013 SHALL, on accepting start, latch op, the absolute values of the operands (for signed ops) and both operand signs; later operand changes SHALL have no effect.
REQ-014 SHALL perform one radix-2 step per CALC cycle.
- Multiply: shift-add.
- Divide: restoring, non-performing.
- Iteration counter runs 31 down to 0.
REQ-015 SHALL apply sign correction in FIX.
- Product negated when the operand signs differ.
- Quotient sign = signA XOR signB.
- Remainder sign = signA.
REQ-016 SHALL write HI/LO at the edge that ends FIX: multiply gives HI=product[63:32], LO=product[31:0]; divide gives LO=quotient, HI=remainder.
REQ-017 SHALL have a fixed latency of 33 cycles from the accepting edge to the HI/LO update edge, with done=1 for exactly the following cycle.
REQ-018 SHALL hold busy=1 in CALC and FIX and busy=0 in IDLE.
REQ-019 SHALL ignore start while busy=1.
REQ-020 SHALL produce, for divide by zero, LO=32'hFFFFFFFF and HI=dataA with the normal latency.
REQ-021 SHALL produce, for DIV 32'h80000000 / 32'hFFFFFFFF, LO=32'h80000000 and HI=0.
REQ-022 SHALL, on flush=1, return to IDLE at the next edge: no HI/LO update, no done, busy=0 the next cycle.
REQ-023 SHALL give flush priority over start in the same cycle.
REQ-024 SHALL apply wr_hi/wr_lo only in IDLE, at the next edge; they are ignored while busy.
REQ-025 SHALL, when start and a write occur in the same IDLE cycle, perform both; the later result overwrites HI/LO.

Reset
REQ-026 SHALL, on reset==0, set state=IDLE, hi=0, lo=0, busy=0, done=0 and clear the counter and all internal registers.
REQ-027 SHALL abort any in-progress operation on reset with no done pulse; reset has priority over flush, start and writes.

Structure
REQ-028 SHALL take the op encodings, state encodings, data width (32) and iteration count (32) from the shared pipeline package/header.
REQ-029 SHALL place operand abs/negate and result sign correction in one combinational sub-module, md_signfix; all sequencing stays in ex_muldiv.

Verification
REQ-030 SHALL cover MULT A=32'hFFFFFFFE, B=3 -> after 33 cycles hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, done pulse 1 cycle.
REQ-031 SHALL cover MULTU with the same operands -> hi=32'h00000002, lo=32'hFFFFFFFA.
REQ-032 SHALL cover DIV A=-7, B=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU A=7, B=0 -> lo=32'hFFFFFFFF, hi=7.
REQ-033 SHALL cover flush at cycle 10 of a DIV, with hi/lo preloaded via wr_hi/wr_lo to 32'h1234/32'h5678 -> busy=0 next cycle, no done, hi/lo unchanged.
REQ-034 SHALL cover start pulses while busy, wr_hi while busy, and reset==0 mid-CALC -> starts and write ignored, reset clears hi/lo to 0 with no done.
